// File: rtl/alu_exec_pkg.sv
// Shared opcode/cond constants, sequencer state encoding and decode helpers
// for the multicycle ALU execute sequencer.
package alu_exec_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADI  = 4'b0001;
   localparam logic [3:0] OP_NDU  = 4'b0010;

   localparam logic [1:0] COND_AL = 2'b00;
   localparam logic [1:0] COND_C  = 2'b10;
   localparam logic [1:0] COND_Z  = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_EXEC,
      ST_WB
   } state_t;

   // ADI ignores cond; the two register-register families reject cond=11.
   function automatic logic is_legal(input logic [15:0] ins);
      logic [3:0] op;
      op = ins[15:12];
      if (op == OP_ADI)
         is_legal = 1'b1;
      else if (op == OP_ADD || op == OP_NDU)
         is_legal = (ins[1:0] != 2'b11);
      else
         is_legal = 1'b0;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute sequencer: reads operands from the register file, drives
// the external ALU, commits the result and owns the C/Z flags.
module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       instr,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic              alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              c_flag,
   output logic              z_flag
);

   state_t              r_state;
   state_t              w_next;
   logic [15:0]         r_instr;
   logic                r_illegal;
   logic [DATA_W-1:0]   r_opa;
   logic [DATA_W-1:0]   r_alu_in1;
   logic [DATA_W-1:0]   r_alu_in2;
   logic                r_alu_op;
   logic [DATA_W-1:0]   r_result;
   logic                r_carry;
   logic                r_c;
   logic                r_z;

   logic [3:0]          w_op;
   logic [REG_AW-1:0]   w_ra;
   logic [REG_AW-1:0]   w_rb;
   logic [REG_AW-1:0]   w_rc;
   logic [1:0]          w_cond;
   logic                w_is_adi;
   logic                w_is_nand;
   logic                w_cond_ok;
   logic                w_we;
   logic [DATA_W-1:0]   w_imm_se;

   assign w_op      = r_instr[15:12];
   assign w_ra      = r_instr[11:9];
   assign w_rb      = r_instr[8:6];
   assign w_rc      = r_instr[5:3];
   assign w_cond    = r_instr[1:0];
   assign w_is_adi  = (w_op == OP_ADI);
   assign w_is_nand = (w_op == OP_NDU);
   assign w_imm_se  = {{(DATA_W-6){r_instr[5]}}, r_instr[5:0]};

   // Condition uses the flags as they stood before this instruction.
   always_comb begin
      w_cond_ok = 1'b0;
      if (w_is_adi)
         w_cond_ok = 1'b1;
      else begin
         case (w_cond)
            COND_AL: w_cond_ok = 1'b1;
            COND_C:  w_cond_ok = r_c;
            COND_Z:  w_cond_ok = r_z;
            default: w_cond_ok = 1'b0;
         endcase
      end
   end

   assign w_we = (r_state == ST_WB) && !r_illegal && w_cond_ok && !reset;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = is_legal(instr) ? ST_RD_A : ST_WB;
         ST_RD_A: w_next = w_is_adi ? ST_EXEC : ST_RD_B;
         ST_RD_B: w_next = ST_EXEC;
         ST_EXEC: w_next = ST_WB;
         ST_WB:   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_instr   <= '0;
         r_illegal <= 1'b0;
         r_opa     <= '0;
         r_alu_in1 <= '0;
         r_alu_in2 <= '0;
         r_alu_op  <= 1'b0;
         r_result  <= '0;
         r_carry   <= 1'b0;
         r_c       <= 1'b0;
         r_z       <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_instr   <= instr;
                  r_illegal <= !is_legal(instr);
               end
            end
            ST_RD_A: begin
               // ADI skips RD_B, so the ALU operands are loaded here.
               if (w_is_adi) begin
                  r_alu_in1 <= rf_rdata;
                  r_alu_in2 <= w_imm_se;
                  r_alu_op  <= 1'b0;
               end else begin
                  r_opa <= rf_rdata;
               end
            end
            ST_RD_B: begin
               r_alu_in1 <= r_opa;
               r_alu_in2 <= rf_rdata;
               r_alu_op  <= w_is_nand;
            end
            ST_EXEC: begin
               r_result <= alu_out;
               r_carry  <= alu_carry;
            end
            ST_WB: begin
               if (w_we) begin
                  if (!w_is_nand) r_c <= r_carry;
                  r_z <= (r_result == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_WB);
   assign illegal  = (r_state == ST_WB) && r_illegal;
   assign rf_raddr = (r_state == ST_RD_B) ? w_rb : w_ra;
   assign rf_we    = w_we;
   assign rf_waddr = w_is_adi ? w_rb : w_rc;
   assign rf_wdata = r_result;
   assign alu_in1  = r_alu_in1;
   assign alu_in2  = r_alu_in2;
   assign alu_op   = r_alu_op;
   assign c_flag   = r_c;
   assign z_flag   = r_z;

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multicycle execute sequencer that sits directly upstream of the 16-bit `alu`. It accepts one arithmetic/logic instruction at a time (ADD, ADC, ADZ, ADI, NDU, NDC, NDZ) and reads its operands from the register file. It then drives the ALU inputs, captures the result and commits it back to the register file. It owns the architectural carry (C) and zero (Z) flags that gate the conditional instruction variants.

## Interface
- `DATA_W`, 16, datapath width; only 16 is supported.
- `REG_AW`, 3, register-file address width (R0–R7).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  instruction-valid strobe; sampled only in IDLE.
- `instr`  in  16  instruction word, sampled when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in WB.
- `illegal`  out  1  one-cycle pulse with `done` for an unsupported opcode or cond=11.
- `rf_raddr`  out  3  register-file read address.
- `rf_rdata`  in  16  read data, combinational from `rf_raddr`.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  3  write address.
- `rf_wdata`  out  16  write data.
- `alu_in1`  out  16  ALU operand 1.
- `alu_in2`  out  16  ALU operand 2.
- `alu_op`  out  1  0 = add, 1 = nand.
- `alu_out`  in  16  ALU result.
- `alu_carry`  in  1  ALU carry-out.
- `c_flag`  out  1  architectural carry flag.
- `z_flag`  out  1  architectural zero flag.

## Operation
- Instruction fields: op=`instr[15:12]`, RA=`[11:9]`, RB=`[8:6]`, RC=`[5:3]`, cond=`[1:0]`, imm6=`[5:0]`.
- Opcode 0000 is the add family; RC = RA + RB.
- Opcode 0010 is the nand family; RC = ~(RA & RB).
- Opcode 0001 is ADI; RB = RA + sign-extended imm6, always written, and cond is not decoded.
- cond encoding for opcodes 0000 and 0010:
  - 00: always write.
  - 10: write only if C=1 (ADC/NDC).
  - 01: write only if Z=1 (ADZ/NDZ).
  - 11: illegal.
- The write condition is evaluated against the flag values held before this instruction.
- Flag update happens only when the write occurs:
  - add/ADI update C from `alu_carry` and set Z = (result == 0).
  - nand updates Z only; C is held.
- A suppressed write leaves both flags unchanged.
- Any other opcode is illegal: no register read, no write, flags held.
- R0 is an ordinary register and is written like any other.
- States:
  - IDLE: `busy`=0. `start`=1 latches `instr`; next state is RD_A if legal, else WB.
  - RD_A: `rf_raddr`=RA; capture opA. Next state is RD_B, or EXEC for ADI, where opB = SE(imm6).
  - RD_B: `rf_raddr`=RB; capture opB; next EXEC.
  - EXEC: `alu_in1`=opA, `alu_in2`=opB, `alu_op` from the opcode. Capture `alu_out` and `alu_carry` into result registers; next WB.
  - WB: `done`=1.
    - `rf_we`=1 if legal and the condition is true.
    - `rf_waddr`=RC, or RB for ADI; `rf_wdata` = captured result.
    - Flags update at the edge that ends WB; next IDLE.
- `start` while `busy` is ignored, and `instr` is not re-sampled.
- `alu_in1`/`alu_in2` hold their last values outside EXEC; `alu_op` holds its last value.

## Timing
- Reset values: state IDLE; `busy`, `done`, `illegal`, `rf_we`, `c_flag`, `z_flag` all 0.
- Reset values: `rf_raddr`, `rf_waddr`, `rf_wdata`, `alu_in1`, `alu_in2`, `alu_op` all 0.
- Cycle numbering: `start` accepted at edge 0.
  - Register-register ops: `done` during cycle 4.
  - ADI: `done` during cycle 3.
  - Illegal: `done` and `illegal` during cycle 1.
- Back-to-back: `start` may be asserted in the cycle right after `done` (IDLE). Minimum issue interval is 5 cycles for register-register ops, 4 for ADI.
- `rf_rdata` and `alu_out` are sampled at the end of the cycle in which they are addressed or driven.
- `reset` in any state: IDLE on the next edge, pending write dropped, flags cleared. `reset` has priority over `start`.
- Result arithmetic is 16-bit modulo 2^16; carry is bit 16 of the unsigned sum.

## Structure
- Shared package `alu_exec_pkg` holds:
  - opcode constants `OP_ADD`=4'b0000, `OP_ADI`=4'b0001, `OP_NDU`=4'b0010;
  - cond constants `COND_AL`, `COND_C`, `COND_Z`;
  - the state enum.
- No sub-module is needed: sign extension and decode are inline.
- The `alu` is instantiated alongside this block by the parent, not inside it.

## Test plan
- ADD R3,R1,R2 with R1=0x0005, R2=0x0003 → cycle 4: `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x0008; C=0, Z=0.
- ADD with 0x8000+0x8000 → writes 0x0000, C=1, Z=1. Then ADC with 0x0001+0x0001 → writes 0x0002, C=0, Z=0.
- ADZ with Z=0 → `done` at cycle 4, `rf_we`=0, C and Z unchanged.
- ADI RB=R5 with R5=0x0000, imm6=0x3F → cycle 3: `rf_waddr`=5, `rf_wdata`=0xFFFF; C=0, Z=0.
- NDU with 0xFFFF nand 0xFFFF, C=1 beforehand → writes 0x0000, Z=1, C stays 1.
- Opcode 0011 → `done`=`illegal`=1 at cycle 1, no write.
- `reset` asserted in EXEC → IDLE next cycle, `busy`=0, flags 0, no write.
- `start` pulsed while `busy` → ignored.
